// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, hold, flush and a bubble counter
// Ports: decode inputs (valid_i, ALU_Operation_i, Read_Data_*_i, Immediate_i, ALU_Src_i, Uses_Rs2_i,
//   Rs1_i/Rs2_i/Rd_i, control bits), hold_i/flush_i, writeback bypass inputs (WB_*),
//   registered ALU-side outputs (A_o, B_o, ALU_Operation_o, Store_Data_o, Rd_o, controls, valid_o),
//   combinational hazard_o and saturating stall_count_o.
// Optional: define FORWARDING_EN to bypass the writeback value into rs1/rs2 at capture.
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic [3:0]             ALU_Operation_i,
    input  logic [DATA_W-1:0]      Read_Data_1_i,
    input  logic [DATA_W-1:0]      Read_Data_2_i,
    input  logic [DATA_W-1:0]      Immediate_i,
    input  logic                   ALU_Src_i,
    input  logic                   Uses_Rs2_i,
    input  logic [REG_ADDR_W-1:0]  Rs1_i,
    input  logic [REG_ADDR_W-1:0]  Rs2_i,
    input  logic [REG_ADDR_W-1:0]  Rd_i,
    input  logic                   Reg_Write_i,
    input  logic                   Mem_Read_i,
    input  logic                   Mem_Write_i,
    input  logic                   Mem_to_Reg_i,
    input  logic                   hold_i,
    input  logic                   flush_i,
    input  logic                   WB_Reg_Write_i,
    input  logic [REG_ADDR_W-1:0]  WB_Rd_i,
    input  logic [DATA_W-1:0]      WB_Data_i,
    output logic                   valid_o,
    output logic [3:0]             ALU_Operation_o,
    output logic [DATA_W-1:0]      A_o,
    output logic [DATA_W-1:0]      B_o,
    output logic [DATA_W-1:0]      Store_Data_o,
    output logic [REG_ADDR_W-1:0]  Rd_o,
    output logic                   Reg_Write_o,
    output logic                   Mem_Read_o,
    output logic                   Mem_Write_o,
    output logic                   Mem_to_Reg_o,
    output logic                   hazard_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);
    typedef struct packed {
        logic                  valid;
        logic [3:0]            op;
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
        logic [DATA_W-1:0]     sd;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
        logic                  mr;
        logic                  mw;
        logic                  m2r;
    } ex_t;
    ex_t ex_q, cap;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic bubble;
`ifdef FORWARDING_EN
    assign rs1_val = (WB_Reg_Write_i && WB_Rd_i != '0 && WB_Rd_i == Rs1_i) ? WB_Data_i : Read_Data_1_i;
    assign rs2_val = (WB_Reg_Write_i && WB_Rd_i != '0 && WB_Rd_i == Rs2_i) ? WB_Data_i : Read_Data_2_i;
`else
    logic unused_wb;
    assign unused_wb = ^{WB_Reg_Write_i, WB_Rd_i, WB_Data_i};
    assign rs1_val   = Read_Data_1_i;
    assign rs2_val   = Read_Data_2_i;
`endif
    assign hazard_o = valid_o & Mem_Read_o & (Rd_o != '0) & valid_i &
                      ((Rd_o == Rs1_i) | (Uses_Rs2_i & (Rd_o == Rs2_i)));
    // A bubble is loaded on flush, or on a hazard when not held.
    assign bubble = flush_i | (~hold_i & hazard_o);
    always_comb begin
        cap.valid = valid_i;
        cap.op    = ALU_Operation_i;
        cap.a     = rs1_val;
        cap.b     = ALU_Src_i ? Immediate_i : rs2_val;
        cap.sd    = rs2_val;
        cap.rd    = Rd_i;
        cap.rw    = Reg_Write_i & valid_i;
        cap.mr    = Mem_Read_i & valid_i;
        cap.mw    = Mem_Write_i & valid_i;
        cap.m2r   = Mem_to_Reg_i & valid_i;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex_q <= '0;
        else if (bubble)
            ex_q <= '0;
        else if (!hold_i)
            ex_q <= cap;
    end
    // Only hazard bubbles are counted; flushes are not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (!flush_i && !hold_i && hazard_o && cnt_q != '1)
            cnt_q <= cnt_q + STALL_CNT_W'(1);
    end
    assign valid_o         = ex_q.valid;
    assign ALU_Operation_o = ex_q.op;
    assign A_o             = ex_q.a;
    assign B_o             = ex_q.b;
    assign Store_Data_o    = ex_q.sd;
    assign Rd_o            = ex_q.rd;
    assign Reg_Write_o     = ex_q.rw;
    assign Mem_Read_o      = ex_q.mr;
    assign Mem_Write_o     = ex_q.mw;
    assign Mem_to_Reg_o    = ex_q.m2r;
    assign stall_count_o   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed bench for id_ex_stage
module tb_id_ex_stage;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] Read_Data_1_i, Read_Data_2_i, Immediate_i;
    logic        ALU_Src_i, Uses_Rs2_i;
    logic [4:0]  Rs1_i, Rs2_i, Rd_i;
    logic        Reg_Write_i, Mem_Read_i, Mem_Write_i, Mem_to_Reg_i;
    logic        hold_i, flush_i;
    logic        WB_Reg_Write_i;
    logic [4:0]  WB_Rd_i;
    logic [31:0] WB_Data_i;
    logic        valid_o;
    logic [3:0]  ALU_Operation_o;
    logic [31:0] A_o, B_o, Store_Data_o;
    logic [4:0]  Rd_o;
    logic        Reg_Write_o, Mem_Read_o, Mem_Write_o, Mem_to_Reg_o;
    logic        hazard_o;
    logic [15:0] stall_count_o;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ALU_Operation_i(ALU_Operation_i),
        .Read_Data_1_i(Read_Data_1_i), .Read_Data_2_i(Read_Data_2_i), .Immediate_i(Immediate_i),
        .ALU_Src_i(ALU_Src_i), .Uses_Rs2_i(Uses_Rs2_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rd_i(Rd_i),
        .Reg_Write_i(Reg_Write_i), .Mem_Read_i(Mem_Read_i), .Mem_Write_i(Mem_Write_i),
        .Mem_to_Reg_i(Mem_to_Reg_i), .hold_i(hold_i), .flush_i(flush_i),
        .WB_Reg_Write_i(WB_Reg_Write_i), .WB_Rd_i(WB_Rd_i), .WB_Data_i(WB_Data_i),
        .valid_o(valid_o), .ALU_Operation_o(ALU_Operation_o), .A_o(A_o), .B_o(B_o),
        .Store_Data_o(Store_Data_o), .Rd_o(Rd_o), .Reg_Write_o(Reg_Write_o),
        .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .Mem_to_Reg_o(Mem_to_Reg_o),
        .hazard_o(hazard_o), .stall_count_o(stall_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [3:0] op; logic [31:0] r1, r2, imm; logic src, u2;
        logic [4:0] rs1, rs2, rd; logic [3:0] ctl; logic hold, flush;
        logic wbw; logic [4:0] wbrd; logic [31:0] wbd;
        logic eh, ev; logic [3:0] eop; logic [31:0] ea, eb, esd;
        logic [4:0] erd; logic [3:0] ectl; logic [15:0] ecnt;
    } vec_t;

    vec_t vq[$];
    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(
        input logic v, input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
        input logic [31:0] imm, input logic src, input logic u2, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] ctl, input logic hold,
        input logic flush, input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
        input logic eh, input logic ev, input logic [3:0] eop, input logic [31:0] ea,
        input logic [31:0] eb, input logic [31:0] esd, input logic [4:0] erd,
        input logic [3:0] ectl, input logic [15:0] ecnt);
        vec_t t;
        t.v = v; t.op = op; t.r1 = r1; t.r2 = r2; t.imm = imm; t.src = src; t.u2 = u2;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.ctl = ctl; t.hold = hold; t.flush = flush;
        t.wbw = wbw; t.wbrd = wbrd; t.wbd = wbd; t.eh = eh; t.ev = ev; t.eop = eop;
        t.ea = ea; t.eb = eb; t.esd = esd; t.erd = erd; t.ectl = ectl; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        valid_i = t.v; ALU_Operation_i = t.op; Read_Data_1_i = t.r1; Read_Data_2_i = t.r2;
        Immediate_i = t.imm; ALU_Src_i = t.src; Uses_Rs2_i = t.u2;
        Rs1_i = t.rs1; Rs2_i = t.rs2; Rd_i = t.rd;
        {Reg_Write_i, Mem_Read_i, Mem_Write_i, Mem_to_Reg_i} = t.ctl;
        hold_i = t.hold; flush_i = t.flush;
        WB_Reg_Write_i = t.wbw; WB_Rd_i = t.wbrd; WB_Data_i = t.wbd;
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({valid_o, ALU_Operation_o, A_o, B_o, Store_Data_o, Rd_o, Reg_Write_o, Mem_Read_o,
             Mem_Write_o, Mem_to_Reg_o, stall_count_o} !== '0) begin
            fails++;
            $display("FAIL %s: got v=%b op=%h a=%h b=%h sd=%h rd=%0d ctl=%b cnt=%0d, want all zero",
                     name, valid_o, ALU_Operation_o, A_o, B_o, Store_Data_o, Rd_o,
                     {Reg_Write_o, Mem_Read_o, Mem_Write_o, Mem_to_Reg_o}, stall_count_o);
        end
    endtask

    initial begin
        vec_t z;
        z = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        reset = 1'b1;
        apply(z);
        #1 check_zero("reset_init");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        vq.push_back(mk(1,4'b0000,32'd5,32'd9,32'd7,1,0,5'd1,5'd2,5'd3,4'b1000,0,0,0,0,0, 0, 1,4'b0000,32'd5,32'd7,32'd9,5'd3,4'b1000,16'd0));
        vq.push_back(mk(1,4'b1001,32'h10,32'h20,32'h30,0,0,5'd4,5'd5,5'd7,4'b1000,0,0,0,0,0, 0, 1,4'b1001,32'h10,32'h20,32'h20,5'd7,4'b1000,16'd0));
        vq.push_back(mk(1,4'b0000,32'h100,32'h55,32'd4,1,0,5'd8,5'd0,5'd6,4'b1101,0,0,0,0,0, 0, 1,4'b0000,32'h100,32'd4,32'h55,5'd6,4'b1101,16'd0));
        vq.push_back(mk(1,4'b0000,32'd1,32'd2,32'd0,0,1,5'd6,5'd9,5'd10,4'b1000,0,0,0,0,0, 1, 0,4'b0000,0,0,0,5'd0,4'b0000,16'd1));
        vq.push_back(mk(1,4'b0000,32'd1,32'd2,32'd0,0,1,5'd6,5'd9,5'd10,4'b1000,0,0,0,0,0, 0, 1,4'b0000,32'd1,32'd2,32'd2,5'd10,4'b1000,16'd1));
        vq.push_back(mk(1,4'b0000,32'd3,32'd0,32'd8,1,0,5'd0,5'd0,5'd12,4'b1101,0,0,0,0,0, 0, 1,4'b0000,32'd3,32'd8,32'd0,5'd12,4'b1101,16'd1));
        vq.push_back(mk(1,4'b0000,32'h40,32'hAB,32'd4,1,1,5'd1,5'd12,5'd0,4'b0010,0,0,0,0,0, 1, 0,4'b0000,0,0,0,5'd0,4'b0000,16'd2));
        vq.push_back(mk(1,4'b0000,32'h40,32'hAB,32'd4,1,1,5'd1,5'd12,5'd0,4'b0010,0,0,0,0,0, 0, 1,4'b0000,32'h40,32'd4,32'hAB,5'd0,4'b0010,16'd2));
        vq.push_back(mk(1,4'b0000,32'd0,32'd0,32'd0,1,0,5'd0,5'd0,5'd12,4'b1101,0,0,0,0,0, 0, 1,4'b0000,32'd0,32'd0,32'd0,5'd12,4'b1101,16'd2));
        vq.push_back(mk(1,4'b1100,32'd7,32'h99,32'd2,1,0,5'd1,5'd12,5'd13,4'b1000,0,0,0,0,0, 0, 1,4'b1100,32'd7,32'd2,32'h99,5'd13,4'b1000,16'd2));
        vq.push_back(mk(1,4'b0000,32'd1,32'd0,32'd1,1,0,5'd0,5'd0,5'd0,4'b1101,0,0,0,0,0, 0, 1,4'b0000,32'd1,32'd1,32'd0,5'd0,4'b1101,16'd2));
        vq.push_back(mk(1,4'b1000,32'd0,32'd0,32'h12345000,1,1,5'd0,5'd0,5'd5,4'b1000,0,0,0,0,0, 0, 1,4'b1000,32'd0,32'h12345000,32'd0,5'd5,4'b1000,16'd2));
        vq.push_back(mk(0,4'b1001,32'hA,32'hB,32'hC,0,0,5'd0,5'd0,5'd9,4'b1111,0,0,0,0,0, 0, 0,4'b1001,32'hA,32'hB,32'hB,5'd9,4'b0000,16'd2));
        vq.push_back(mk(1,4'b0000,32'd2,32'd0,32'd3,1,0,5'd0,5'd0,5'd14,4'b1101,0,0,0,0,0, 0, 1,4'b0000,32'd2,32'd3,32'd0,5'd14,4'b1101,16'd2));
        vq.push_back(mk(1,4'b0000,32'h11,32'h22,32'd0,0,0,5'd14,5'd0,5'd15,4'b1000,1,0,0,0,0, 1, 1,4'b0000,32'd2,32'd3,32'd0,5'd14,4'b1101,16'd2));
        vq.push_back(mk(1,4'b0000,32'h11,32'h22,32'd0,0,0,5'd14,5'd0,5'd15,4'b1000,1,1,0,0,0, 1, 0,4'b0000,0,0,0,5'd0,4'b0000,16'd2));
        vq.push_back(mk(1,4'b0000,32'h11,32'h22,32'd0,0,0,5'd14,5'd0,5'd15,4'b1000,0,0,0,0,0, 0, 1,4'b0000,32'h11,32'h22,32'h22,5'd15,4'b1000,16'd2));
        vq.push_back(mk(1,4'b1100,32'd1,32'd2,32'd3,1,1,5'd15,5'd15,5'd1,4'b1111,1,0,0,0,0, 0, 1,4'b0000,32'h11,32'h22,32'h22,5'd15,4'b1000,16'd2));
        vq.push_back(mk(0,4'b1001,32'd4,32'd5,32'd6,0,0,5'd2,5'd3,5'd4,4'b0100,1,0,0,0,0, 0, 1,4'b0000,32'h11,32'h22,32'h22,5'd15,4'b1000,16'd2));
        vq.push_back(mk(1,4'b1000,32'd7,32'd8,32'd9,1,0,5'd6,5'd7,5'd8,4'b1101,1,0,0,0,0, 0, 1,4'b0000,32'h11,32'h22,32'h22,5'd15,4'b1000,16'd2));
        vq.push_back(mk(1,4'b0000,32'd0,32'h77,32'd0,0,1,5'd2,5'd2,5'd1,4'b1000,0,0,1,5'd2,32'hDEADBEEF, 0, 1,4'b0000,
                        FWD ? 32'hDEADBEEF : 32'd0, FWD ? 32'hDEADBEEF : 32'h77, FWD ? 32'hDEADBEEF : 32'h77, 5'd1,4'b1000,16'd2));
        vq.push_back(mk(1,4'b0000,32'd5,32'd6,32'd0,0,1,5'd0,5'd0,5'd2,4'b1000,0,0,1,5'd0,32'hDEADBEEF, 0, 1,4'b0000,32'd5,32'd6,32'd6,5'd2,4'b1000,16'd2));
        vq.push_back(mk(1,4'b0000,32'd6,32'd7,32'd0,0,1,5'd3,5'd3,5'd4,4'b1000,0,0,0,5'd3,32'hDEADBEEF, 0, 1,4'b0000,32'd6,32'd7,32'd7,5'd4,4'b1000,16'd2));

        foreach (vq[i]) begin
            apply(vq[i]);
            #1;
            tests++;
            if (hazard_o !== vq[i].eh) begin
                fails++;
                $display("FAIL vec%0d hazard: got %b want %b", i, hazard_o, vq[i].eh);
            end
            @(posedge clk);
            #1;
            tests++;
            if ({valid_o, ALU_Operation_o, A_o, B_o, Store_Data_o, Rd_o,
                 Reg_Write_o, Mem_Read_o, Mem_Write_o, Mem_to_Reg_o, stall_count_o} !==
                {vq[i].ev, vq[i].eop, vq[i].ea, vq[i].eb, vq[i].esd, vq[i].erd, vq[i].ectl, vq[i].ecnt}) begin
                fails++;
                $display("FAIL vec%0d outputs: got v=%b op=%h a=%h b=%h sd=%h rd=%0d ctl=%b cnt=%0d want v=%b op=%h a=%h b=%h sd=%h rd=%0d ctl=%b cnt=%0d",
                         i, valid_o, ALU_Operation_o, A_o, B_o, Store_Data_o, Rd_o,
                         {Reg_Write_o, Mem_Read_o, Mem_Write_o, Mem_to_Reg_o}, stall_count_o,
                         vq[i].ev, vq[i].eop, vq[i].ea, vq[i].eb, vq[i].esd, vq[i].erd, vq[i].ectl, vq[i].ecnt);
            end
        end

        // Mid-stream asynchronous reset: EX holds a valid instruction and the counter is nonzero.
        tests++;
        if (!(valid_o === 1'b1 && stall_count_o === 16'd2)) begin
            fails++;
            $display("FAIL pre_reset_state: got v=%b cnt=%0d want v=1 cnt=2", valid_o, stall_count_o);
        end
        #2 reset = 1'b1;
        #1 check_zero("async_reset_mid");
        @(posedge clk);
        #1 check_zero("reset_held_edge");
        reset = 1'b0;
        apply(vq[0]);
        @(posedge clk);
        #1;
        tests++;
        if ({valid_o, A_o, B_o, Rd_o} !== {1'b1, 32'd5, 32'd7, 5'd3}) begin
            fails++;
            $display("FAIL post_reset_capture: got v=%b a=%h b=%h rd=%0d want v=1 a=5 b=7 rd=3",
                     valid_o, A_o, B_o, Rd_o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
